// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser followed by a four-state debounce FSM.
// A new level is accepted only after it has been seen for DEBOUNCE_CYCLES+1 consecutive samples.
module button_debounce #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic btn_db,
   output logic btn_chg
);

   typedef enum logic [1:0] {
      ST_LOW    = 2'd0,
      WAIT_HIGH = 2'd1,
      ST_HIGH   = 2'd2,
      WAIT_LOW  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   state_t           state;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn_raw;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_LOW;
         cnt     <= '0;
         btn_db  <= 1'b0;
         btn_chg <= 1'b0;
      end else begin
         btn_chg <= 1'b0;
         case (state)
            ST_LOW: begin
               if (s2) begin
                  state <= WAIT_HIGH;
                  cnt   <= '0;
               end
            end
            WAIT_HIGH: begin
               // Any return to the accepted level restarts the window from zero.
               if (!s2) begin
                  state <= ST_LOW;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state   <= ST_HIGH;
                  btn_db  <= 1'b1;
                  btn_chg <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_HIGH: begin
               if (!s2) begin
                  state <= WAIT_LOW;
                  cnt   <= '0;
               end
            end
            WAIT_LOW: begin
               if (s2) begin
                  state <= ST_HIGH;
                  cnt   <= '0;
               end else if (cnt == CNT_LAST) begin
                  state   <= ST_LOW;
                  btn_db  <= 1'b0;
                  btn_chg <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= ST_LOW;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
